writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage of the 8-bit core, downstream of the execute stage. Accepts one executed instruction per handshake, commits results to an 8×8 register file, stores to data memory through a request/acknowledge port, and latches the architectural flags. It also sources the execute stage's register operands through two combinational read ports, closing the loop with execute.

## Interface

Parameters:
- `RETIRE_W`, 16: width of the retired-instruction counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: an executed instruction is presented.
- `in_ready` output 1: stage can accept this cycle.
- `opcode` input 5: instruction opcode; same encoding as the execute stage.
- `rd` input 3: destination register.
- `mem_addr` input 4: store address.
- `result` input 16: execute result.
- `zero_in`, `carry_in`, `ac_in`, `parity_in` input 1 each: flags from execute.
- `rd_addr_a`, `rd_addr_b` input 3 each: register read addresses.
- `rd_data_a`, `rd_data_b` output 8 each: register read data (operand_1 / rs2_data to execute).
- `mem_we` output 1: store request.
- `mem_waddr` output 4: store address.
- `mem_wdata` output 8: store data.
- `mem_ack` input 1: memory accepted the store.
- `zero_flag`, `carry_flag`, `ac_flag`, `parity_flag` output 1 each: architectural flags.
- `halted` output 1: HALT retired.
- `retired_count` output RETIRE_W: retired instructions, wraps modulo 2^RETIRE_W.

## Operation

- Accept = `in_valid && in_ready`. `in_ready` = 1 only in state IDLE.
- FSM states: IDLE, WR_HI, MEM_WR, HALTED.
- IDLE, on accept:
  - MUL 00011 / DIV 00100: write `result[7:0]` to `rd` and go to WR_HI. The high byte `result[15:8]` (DIV remainder) is latched.
  - STORE 01100: latch `result[7:0]`→`mem_wdata` and `mem_addr`→`mem_waddr`, then go to MEM_WR.
  - HALT 11111: go to HALTED.
  - Single-byte writers write `result[7:0]` to `rd` and stay IDLE:
    - MOV 00000, ADD 00001, SUB 00010, INC 00101, DEC 00110
    - AND 00111, OR 01000, NOT 01001, XOR 01010
    - LOAD 01011, shifts/rotates 10000–10101.
  - JUMP 01101, branches 01110/10110/10111/11000, COMPARE 11001, and unused opcodes: no register write, stay IDLE.
- WR_HI: write the latched high byte to `(rd+1) mod 8`, retire, return to IDLE. Example: rd=7 writes r0.
- MEM_WR: `mem_we`=1 with stable `mem_waddr`/`mem_wdata` until a cycle with `mem_ack`=1. That cycle retires and returns to IDLE.
- HALTED: `halted`=1, `in_ready`=0. Exited only by `reset`.
- Flag update: latched on accept, and only for the listed flags; all other flags hold.
  - ADD/SUB/INC/DEC: Z, C, AC, P.
  - Shifts 10000–10011: Z, C, P.
  - Rotates 10100–10101, MOV, logic ops, MUL, DIV, COMPARE: Z, P.
  - LOAD, STORE, JUMP, branches, HALT, unused opcodes: none.
- Retire: `retired_count` increments by 1 when an instruction completes:
  - accept of a one-cycle op, including HALT and no-write ops;
  - the WR_HI cycle;
  - the acked MEM_WR cycle.
- Register file: r0–r7 all writable. Reads are combinational from stored contents, with no write bypass.
- Inputs are ignored when not accepted; x/z values on them never reach state.

## Timing

- Reset (synchronous, takes effect at the edge):
  - all registers r0–r7 = 0, all flags = 0, `retired_count` = 0;
  - `mem_we` = 0, `mem_waddr` = 0, `mem_wdata` = 0, `halted` = 0;
  - state IDLE, so `in_ready` = 1 in the cycle after reset.
- Reset in WR_HI abandons the high-byte write. Reset in MEM_WR drops `mem_we` in the next cycle and does not retire.
- Single-byte write accepted at edge N is visible on `rd_data_*` after edge N; a read in the accept cycle returns the old value.
- MUL/DIV: low byte visible after edge N, high byte after edge N+1. `in_ready`=0 for one cycle.
- STORE: `mem_we` rises after edge N. With `mem_ack` high in the first MEM_WR cycle, the store lasts exactly one cycle and `in_ready` returns the cycle after. The stall is unbounded while `mem_ack`=0.
- `mem_ack` outside MEM_WR is ignored.
- Throughput: one instruction per cycle for single-cycle ops.

## Test plan

- Reset, then ADD rd=3, result=16'h0000, zero_in=1, carry_in=1, ac_in=1, parity_in=0 → r3=0; Z=1, C=1, AC=1, P=0; count=1; `in_ready` stays 1.
- MUL rd=7, result=16'hA55A → r7=8'h5A after edge N, r0=8'hA5 after N+1; `in_ready`=0 for exactly one cycle; count +1.
- STORE mem_addr=4'hC, result[7:0]=8'h3E, `mem_ack` held low 3 cycles then high → `mem_we`=1 with addr C/data 3E for 4 cycles, then 0; count +1 only at the ack.
- Rotate 10100 with carry_in=1 after a prior SUB left C=0 → C stays 0; Z/P follow the inputs. LOAD with zero_in=1 → flags unchanged.
- HALT, then in_valid=1 with ADD → `halted`=1, `in_ready`=0, no write. Reset → `halted`=0, `in_ready`=1.
- Reset asserted in the second MEM_WR cycle → `mem_we`=0 next cycle, count=0, all registers 0.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage of the 8-bit core.
// Commits execute results to an 8x8 register file. MUL/DIV write their
// second byte one cycle later. STOREs go out through a request/ack port.
// The stage latches the architectural flags and counts retired instructions.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   in_valid/in_ready             - instruction handshake from execute
//   opcode, rd, mem_addr, result  - executed instruction payload
//   zero/carry/ac/parity_in       - flags produced by execute
//   rd_addr_a/b, rd_data_a/b      - combinational operand read ports
//   mem_we/waddr/wdata, mem_ack   - data-memory store port
//   *_flag                        - architectural flags
//   halted, retired_count         - status
module writeback_stage #(
  parameter int unsigned RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          opcode,
  input  logic [2:0]          rd,
  input  logic [3:0]          mem_addr,
  input  logic [15:0]         result,
  input  logic                zero_in,
  input  logic                carry_in,
  input  logic                ac_in,
  input  logic                parity_in,
  input  logic [2:0]          rd_addr_a,
  input  logic [2:0]          rd_addr_b,
  output logic [7:0]          rd_data_a,
  output logic [7:0]          rd_data_b,
  output logic                mem_we,
  output logic [3:0]          mem_waddr,
  output logic [7:0]          mem_wdata,
  input  logic                mem_ack,
  output logic                zero_flag,
  output logic                carry_flag,
  output logic                ac_flag,
  output logic                parity_flag,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired_count
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned REG_N  = 8;
  localparam int unsigned RADR_W = 3;

  localparam logic [4:0] OP_MOV   = 5'b00000;
  localparam logic [4:0] OP_ADD   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_MUL   = 5'b00011;
  localparam logic [4:0] OP_DIV   = 5'b00100;
  localparam logic [4:0] OP_INC   = 5'b00101;
  localparam logic [4:0] OP_DEC   = 5'b00110;
  localparam logic [4:0] OP_AND   = 5'b00111;
  localparam logic [4:0] OP_OR    = 5'b01000;
  localparam logic [4:0] OP_NOT   = 5'b01001;
  localparam logic [4:0] OP_XOR   = 5'b01010;
  localparam logic [4:0] OP_LOAD  = 5'b01011;
  localparam logic [4:0] OP_STORE = 5'b01100;
  localparam logic [4:0] OP_SH0   = 5'b10000;
  localparam logic [4:0] OP_SH1   = 5'b10001;
  localparam logic [4:0] OP_SH2   = 5'b10010;
  localparam logic [4:0] OP_SH3   = 5'b10011;
  localparam logic [4:0] OP_ROT0  = 5'b10100;
  localparam logic [4:0] OP_ROT1  = 5'b10101;
  localparam logic [4:0] OP_CMP   = 5'b11001;
  localparam logic [4:0] OP_HALT  = 5'b11111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR_HI,
    S_MEM_WR,
    S_HALTED
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] regs [REG_N];
  logic [DATA_W-1:0] hi_byte;
  logic [RADR_W-1:0] hi_rd;

  // Opcode classification
  logic wr_lo, wide, store, halt_op, upd_zp, upd_c, upd_ac;

  // FSM controls
  logic              accept;
  logic              rf_we;
  logic [RADR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              retire;
  logic              lat_hi;
  logic              lat_st;

  // Decode: which results are written and which flags the opcode owns
  always_comb begin
    wr_lo   = 1'b0;
    wide    = 1'b0;
    store   = 1'b0;
    halt_op = 1'b0;
    upd_zp  = 1'b0;
    upd_c   = 1'b0;
    upd_ac  = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        wr_lo = 1'b1; upd_zp = 1'b1; upd_c = 1'b1; upd_ac = 1'b1;
      end
      OP_MOV, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_ROT0, OP_ROT1: begin
        wr_lo = 1'b1; upd_zp = 1'b1;
      end
      OP_SH0, OP_SH1, OP_SH2, OP_SH3: begin
        wr_lo = 1'b1; upd_zp = 1'b1; upd_c = 1'b1;
      end
      OP_MUL, OP_DIV: begin
        wide = 1'b1; upd_zp = 1'b1;
      end
      OP_LOAD:  wr_lo   = 1'b1;
      OP_STORE: store   = 1'b1;
      OP_CMP:   upd_zp  = 1'b1;
      OP_HALT:  halt_op = 1'b1;
      default: ;
    endcase
  end

  // Next-state and datapath controls
  always_comb begin
    state_n  = state;
    accept   = in_valid && (state == S_IDLE);
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = result[DATA_W-1:0];
    retire   = 1'b0;
    lat_hi   = 1'b0;
    lat_st   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (wide) begin
            rf_we   = 1'b1;
            lat_hi  = 1'b1;
            state_n = S_WR_HI;
          end else if (store) begin
            lat_st  = 1'b1;
            state_n = S_MEM_WR;
          end else if (halt_op) begin
            retire  = 1'b1;
            state_n = S_HALTED;
          end else begin
            rf_we  = wr_lo;
            retire = 1'b1;
          end
        end
      end
      S_WR_HI: begin
        rf_we    = 1'b1;
        rf_waddr = hi_rd;
        rf_wdata = hi_byte;
        retire   = 1'b1;
        state_n  = S_IDLE;
      end
      S_MEM_WR: begin
        if (mem_ack) begin
          retire  = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_HALTED: ;
      default: state_n = S_IDLE;
    endcase
  end

  // State register with registered status outputs derived from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      in_ready <= 1'b1;
      halted   <= 1'b0;
      mem_we   <= 1'b0;
    end else begin
      state    <= state_n;
      in_ready <= (state_n == S_IDLE);
      halted   <= (state_n == S_HALTED);
      mem_we   <= (state_n == S_MEM_WR);
    end
  end

  // Register file, latches, flags and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
      hi_byte       <= '0;
      hi_rd         <= '0;
      mem_waddr     <= '0;
      mem_wdata     <= '0;
      zero_flag     <= 1'b0;
      carry_flag    <= 1'b0;
      ac_flag       <= 1'b0;
      parity_flag   <= 1'b0;
      retired_count <= '0;
    end else begin
      if (rf_we) regs[rf_waddr] <= rf_wdata;
      if (lat_hi) begin
        hi_byte <= result[15:8];
        hi_rd   <= rd + 3'd1;   // wraps r7 -> r0
      end
      if (lat_st) begin
        mem_waddr <= mem_addr;
        mem_wdata <= result[DATA_W-1:0];
      end
      if (accept && upd_zp) begin
        zero_flag   <= zero_in;
        parity_flag <= parity_in;
      end
      if (accept && upd_c)  carry_flag <= carry_in;
      if (accept && upd_ac) ac_flag    <= ac_in;
      if (retire) retired_count <= retired_count + RETIRE_W'(1);
    end
  end

  // Operand reads see stored contents only (no write bypass)
  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

endmodule

// File: tb/tb_writeback_stage.sv
`timescale 1ns/1ps
module tb_writeback_stage;
  localparam int unsigned RETIRE_W = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [4:0]          opcode;
  logic [2:0]          rd;
  logic [3:0]          mem_addr;
  logic [15:0]         result;
  logic                zero_in, carry_in, ac_in, parity_in;
  logic [2:0]          rd_addr_a, rd_addr_b;
  logic [7:0]          rd_data_a, rd_data_b;
  logic                mem_we;
  logic [3:0]          mem_waddr;
  logic [7:0]          mem_wdata;
  logic                mem_ack;
  logic                zero_flag, carry_flag, ac_flag, parity_flag;
  logic                halted;
  logic [RETIRE_W-1:0] retired_count;

  writeback_stage #(.RETIRE_W(RETIRE_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .mem_addr(mem_addr), .result(result),
    .zero_in(zero_in), .carry_in(carry_in), .ac_in(ac_in), .parity_in(parity_in),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .ac_flag(ac_flag),
    .parity_flag(parity_flag), .halted(halted), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Architectural reference model
  logic [7:0]          mregs [8];
  logic                mz, mc, mac, mp;
  logic [RETIRE_W-1:0] mcount;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    {mz, mc, mac, mp} = 4'b0000;
    mcount = '0;
  endtask

  function automatic bit writes_low(input logic [4:0] op);
    return op inside {5'd0, 5'd1, 5'd2, 5'd5, 5'd6, [5'd7:5'd11], [5'd16:5'd21]};
  endfunction

  // f = {zero, carry, ac, parity}
  task automatic model_flags(input logic [4:0] op, input logic [3:0] f);
    if (op inside {5'd1, 5'd2, 5'd5, 5'd6}) {mz, mc, mac, mp} = f;
    else if (op inside {[5'd16:5'd19]}) begin mz = f[3]; mc = f[2]; mp = f[0]; end
    else if (op inside {5'd0, 5'd3, 5'd4, [5'd7:5'd10], 5'd20, 5'd21, 5'd25}) begin
      mz = f[3]; mp = f[0];
    end
  endtask

  task automatic model_accept(input logic [4:0] op, input logic [2:0] r,
                              input logic [15:0] res, input logic [3:0] f);
    model_flags(op, f);
    if (writes_low(op)) mregs[r] = res[7:0];
    mcount = mcount + 1'b1;
  endtask

  task automatic scramble;
    opcode   = 5'($urandom);
    rd       = 3'($urandom);
    mem_addr = 4'($urandom);
    result   = 16'($urandom);
    {zero_in, carry_in, ac_in, parity_in} = 4'($urandom);
  endtask

  task automatic check_state;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(7 - i);
      #1;
      check($sformatf("reg_a r%0d", i), 32'(rd_data_a), 32'(mregs[i]));
      check($sformatf("reg_b r%0d", 7 - i), 32'(rd_data_b), 32'(mregs[7 - i]));
    end
    check("zero_flag", 32'(zero_flag), 32'(mz));
    check("carry_flag", 32'(carry_flag), 32'(mc));
    check("ac_flag", 32'(ac_flag), 32'(mac));
    check("parity_flag", 32'(parity_flag), 32'(mp));
    check("retired_count", 32'(retired_count), 32'(mcount));
    @(negedge clk);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    in_valid = 1'b0;
    tick;
    reset = 1'b0;
    model_clear;
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_waddr", 32'(mem_waddr), 32'd0);
    check("rst mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst halted", 32'(halted), 32'd0);
    check_state;
  endtask

  // One instruction from accept to completion; starts at a negedge in IDLE
  task automatic exec(input logic [4:0] op, input logic [2:0] r, input logic [3:0] a,
                      input logic [15:0] res, input logic [3:0] f, input int ack_wait);
    logic [2:0] nxt;
    nxt = r + 3'd1;
    check("ready before accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1; opcode = op; rd = r; mem_addr = a; result = res;
    {zero_in, carry_in, ac_in, parity_in} = f;
    mem_ack = 1'($urandom);
    rd_addr_a = r;
    rd_addr_b = nxt;
    #1;
    check("read in accept cycle is old", 32'(rd_data_a), 32'(mregs[r]));
    tick;
    in_valid = 1'b0;
    mem_ack  = 1'b0;
    scramble;
    if (op == 5'd3 || op == 5'd4) begin
      model_flags(op, f);
      mregs[r] = res[7:0];
      check("wide low byte", 32'(rd_data_a), 32'(res[7:0]));
      if (nxt != r) check("wide high not yet", 32'(rd_data_b), 32'(mregs[nxt]));
      check("wide stall", 32'(in_ready), 32'd0);
      check("wide count pending", 32'(retired_count), 32'(mcount));
      tick;
      mregs[nxt] = res[15:8];
      mcount = mcount + 1'b1;
      check("wide high byte", 32'(rd_data_b), 32'(res[15:8]));
      check("wide ready back", 32'(in_ready), 32'd1);
    end else if (op == 5'd12) begin
      check("store we", 32'(mem_we), 32'd1);
      check("store addr", 32'(mem_waddr), 32'(a));
      check("store data", 32'(mem_wdata), 32'(res[7:0]));
      check("store stall", 32'(in_ready), 32'd0);
      for (int k = 0; k < ack_wait; k++) begin
        mem_ack = 1'b0;
        tick;
        scramble;
        check("store wait we", 32'(mem_we), 32'd1);
        check("store wait addr", 32'(mem_waddr), 32'(a));
        check("store wait data", 32'(mem_wdata), 32'(res[7:0]));
        check("store wait count", 32'(retired_count), 32'(mcount));
      end
      mem_ack = 1'b1;
      tick;
      mem_ack = 1'b0;
      mcount = mcount + 1'b1;
      check("store done we", 32'(mem_we), 32'd0);
      check("store done ready", 32'(in_ready), 32'd1);
    end else begin
      model_accept(op, r, res, f);
      check("single ready", 32'(in_ready), 32'(op != 5'd31));
      check("single halted", 32'(halted), 32'(op == 5'd31));
    end
    check_state;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; mem_ack = 1'b0;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    scramble;
    @(negedge clk);
    do_reset;

    // ADD writing zero with Z/C/AC set, P clear
    exec(5'd1, 3'd3, 4'h0, 16'h0000, 4'b1110, 0);
    // MUL into r7: high byte wraps to r0
    exec(5'd3, 3'd7, 4'h0, 16'hA55A, 4'b0001, 0);
    // STORE with three cycles of back-pressure
    exec(5'd12, 3'd0, 4'hC, 16'h003E, 4'b1111, 3);
    // SUB clears C; rotate must not take carry; LOAD touches no flag
    exec(5'd2, 3'd1, 4'h0, 16'h0042, 4'b0000, 0);
    exec(5'd20, 3'd2, 4'h0, 16'h0081, 4'b1101, 0);
    exec(5'd11, 3'd4, 4'h0, 16'h0077, 4'b1111, 0);
    // DIV with remainder into rd+1
    exec(5'd4, 3'd2, 4'h0, 16'h0305, 4'b0000, 1);

    // Back-to-back single-cycle accepts
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      opcode = 5'd5; rd = 3'(k + 4); result = 16'($urandom);
      {zero_in, carry_in, ac_in, parity_in} = 4'($urandom);
      tick;
      model_accept(opcode, rd, result, {zero_in, carry_in, ac_in, parity_in});
      check("b2b count", 32'(retired_count), 32'(mcount));
      check("b2b ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    check_state;

    // Randomized instruction stream (HALT excluded)
    for (int n = 0; n < 40; n++) begin
      exec(5'($urandom_range(0, 30)), 3'($urandom), 4'($urandom), 16'($urandom),
           4'($urandom), int'($urandom_range(0, 3)));
    end

    // HALT, then further requests are refused
    exec(5'd31, 3'd0, 4'h0, 16'h0000, 4'b1111, 0);
    in_valid = 1'b1; opcode = 5'd1; rd = 3'd5; result = 16'h0099;
    {zero_in, carry_in, ac_in, parity_in} = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("halt halted", 32'(halted), 32'd1);
      check("halt ready", 32'(in_ready), 32'd0);
      check("halt count", 32'(retired_count), 32'(mcount));
    end
    in_valid = 1'b0;
    check_state;
    do_reset;

    // Reset during the second MEM_WR cycle abandons the store
    exec(5'd1, 3'd6, 4'h0, 16'h00AB, 4'b0000, 0);
    in_valid = 1'b1; opcode = 5'd12; mem_addr = 4'h9; result = 16'h0055; mem_ack = 1'b0;
    tick;
    in_valid = 1'b0;
    tick;
    check("mem_wr2 we", 32'(mem_we), 32'd1);
    reset = 1'b1; mem_ack = 1'b1;
    tick;
    reset = 1'b0; mem_ack = 1'b0;
    model_clear;
    check("rst in store we", 32'(mem_we), 32'd0);
    check("rst in store ready", 32'(in_ready), 32'd1);
    check_state;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
